// File: rtl/bullet_controller_if.sv
// Signal bundle between the bullet controller and its neighbours: frame tick, keyboard
// fire/direction, ball centres in; bullet state, hit pulses, scores and FSM state out.
interface bullet_controller_if;
  logic       frame_tick;
  logic       fire1;
  logic       fire2;
  logic [1:0] dir1;
  logic [1:0] dir2;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] Ball2X;
  logic [9:0] Ball2Y;
  logic [9:0] BulletX;
  logic [9:0] BulletY;
  logic [9:0] Bullet2X;
  logic [9:0] Bullet2Y;
  logic       bullet_on;
  logic       bullet2_on;
  logic       hit1;
  logic       hit2;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] state1_dbg;
  logic [1:0] state2_dbg;

  modport master (
    output frame_tick, fire1, fire2, dir1, dir2, BallX, BallY, Ball2X, Ball2Y,
    input  BulletX, BulletY, Bullet2X, Bullet2Y, bullet_on, bullet2_on,
    input  hit1, hit2, score1, score2, state1_dbg, state2_dbg
  );

  modport slave (
    input  frame_tick, fire1, fire2, dir1, dir2, BallX, BallY, Ball2X, Ball2Y,
    output BulletX, BulletY, Bullet2X, Bullet2Y, bullet_on, bullet2_on,
    output hit1, hit2, score1, score2, state1_dbg, state2_dbg
  );
endinterface

// File: rtl/bullet_controller.sv
// Two independent bullet FSMs (IDLE/FLY/HIT/COOL) sharing one frame tick; each bullet
// launches from its owner's ball and can only hit the opposing ball.
module bullet_controller #(
  parameter int X_MAX    = 639,
  parameter int Y_MAX    = 479,
  parameter int SPEED    = 4,
  parameter int HIT_DIST = 8,
  parameter int COOLDOWN = 30
) (
  input  logic                Clk,
  input  logic                Reset,
  bullet_controller_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_HIT  = 2'd2,
    S_COOL = 2'd3
  } state_t;

  localparam logic [10:0] L_XMAX  = 11'(X_MAX);
  localparam logic [10:0] L_YMAX  = 11'(Y_MAX);
  localparam logic [10:0] L_SPEED = 11'(SPEED);
  localparam logic [10:0] L_HIT   = 11'(HIT_DIST);
  localparam logic [7:0]  L_COOL  = 8'(COOLDOWN);

  // Index 0 is player 1's bullet, index 1 is player 2's.
  logic [9:0] w_own_x [2];
  logic [9:0] w_own_y [2];
  logic [9:0] w_opp_x [2];
  logic [9:0] w_opp_y [2];
  logic       w_fire  [2];
  logic [1:0] w_dir   [2];
  logic [9:0] w_bx    [2];
  logic [9:0] w_by    [2];
  logic       w_on    [2];
  logic       w_hit   [2];
  logic [3:0] w_score [2];
  logic [1:0] w_state [2];

  assign w_own_x[0] = io_bus.BallX;
  assign w_own_y[0] = io_bus.BallY;
  assign w_opp_x[0] = io_bus.Ball2X;
  assign w_opp_y[0] = io_bus.Ball2Y;
  assign w_fire[0]  = io_bus.fire1;
  assign w_dir[0]   = io_bus.dir1;
  assign w_own_x[1] = io_bus.Ball2X;
  assign w_own_y[1] = io_bus.Ball2Y;
  assign w_opp_x[1] = io_bus.BallX;
  assign w_opp_y[1] = io_bus.BallY;
  assign w_fire[1]  = io_bus.fire2;
  assign w_dir[1]   = io_bus.dir2;

  for (genvar p = 0; p < 2; p++) begin : g_bullet
    state_t      r_state, w_state_nxt;
    logic [9:0]  r_x, r_y, w_x_nxt, w_y_nxt;
    logic [1:0]  r_dir, w_dir_nxt;
    logic        r_on, r_hit, r_fire_prev;
    logic [3:0]  r_score, w_score_nxt;
    logic [7:0]  r_cool, w_cool_nxt;
    logic [10:0] w_dx, w_dy, w_sum_x, w_sum_y;
    logic        w_near, w_launch, w_expire;

    assign w_dx     = (r_x >= w_opp_x[p]) ? {1'b0, r_x - w_opp_x[p]} : {1'b0, w_opp_x[p] - r_x};
    assign w_dy     = (r_y >= w_opp_y[p]) ? {1'b0, r_y - w_opp_y[p]} : {1'b0, w_opp_y[p] - r_y};
    assign w_near   = (w_dx <= L_HIT) && (w_dy <= L_HIT);
    // 11-bit sums so a step past the right/bottom edge is seen instead of wrapping.
    assign w_sum_x  = {1'b0, r_x} + L_SPEED;
    assign w_sum_y  = {1'b0, r_y} + L_SPEED;
    assign w_launch = io_bus.frame_tick && w_fire[p] && !r_fire_prev;

    always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_dir_nxt   = r_dir;
      w_cool_nxt  = r_cool;
      w_score_nxt = r_score;
      w_expire    = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            w_state_nxt = S_FLY;
            w_x_nxt     = w_own_x[p];
            w_y_nxt     = w_own_y[p];
            w_dir_nxt   = w_dir[p];
          end
        end
        S_FLY: begin
          if (w_near) begin
            w_state_nxt = S_HIT;
            if (r_score != 4'hF) w_score_nxt = r_score + 4'd1;
          end else if (io_bus.frame_tick) begin
            case (r_dir)
              2'd0: if ({1'b0, r_y} < L_SPEED) w_expire = 1'b1;
                    else w_y_nxt = r_y - L_SPEED[9:0];
              2'd1: if (w_sum_x > L_XMAX) w_expire = 1'b1;
                    else w_x_nxt = w_sum_x[9:0];
              2'd2: if (w_sum_y > L_YMAX) w_expire = 1'b1;
                    else w_y_nxt = w_sum_y[9:0];
              default: if ({1'b0, r_x} < L_SPEED) w_expire = 1'b1;
                       else w_x_nxt = r_x - L_SPEED[9:0];
            endcase
          end
        end
        S_HIT: begin
          w_state_nxt = S_COOL;
          w_cool_nxt  = L_COOL;
        end
        default: begin
          if (io_bus.frame_tick) begin
            w_cool_nxt = (r_cool == 8'd0) ? 8'd0 : r_cool - 8'd1;
            if (r_cool <= 8'd1) w_state_nxt = S_IDLE;
          end
        end
      endcase
      if (w_expire) begin
        w_state_nxt = S_COOL;
        w_cool_nxt  = L_COOL;
      end
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        r_state     <= S_IDLE;
        r_x         <= 10'd0;
        r_y         <= 10'd0;
        r_dir       <= 2'd0;
        r_on        <= 1'b0;
        r_hit       <= 1'b0;
        r_score     <= 4'd0;
        r_cool      <= 8'd0;
        // Treat fire as already held so a press spanning reset must be released first.
        r_fire_prev <= 1'b1;
      end else begin
        r_state <= w_state_nxt;
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        r_dir   <= w_dir_nxt;
        r_on    <= (w_state_nxt == S_FLY);
        r_hit   <= (w_state_nxt == S_HIT);
        r_score <= w_score_nxt;
        r_cool  <= w_cool_nxt;
        if (io_bus.frame_tick) r_fire_prev <= w_fire[p];
      end
    end

    assign w_bx[p]    = r_x;
    assign w_by[p]    = r_y;
    assign w_on[p]    = r_on;
    assign w_hit[p]   = r_hit;
    assign w_score[p] = r_score;
    assign w_state[p] = r_state;
  end

  assign io_bus.BulletX    = w_bx[0];
  assign io_bus.BulletY    = w_by[0];
  assign io_bus.bullet_on  = w_on[0];
  assign io_bus.hit1       = w_hit[0];
  assign io_bus.score1     = w_score[0];
  assign io_bus.state1_dbg = w_state[0];
  assign io_bus.Bullet2X   = w_bx[1];
  assign io_bus.Bullet2Y   = w_by[1];
  assign io_bus.bullet2_on = w_on[1];
  assign io_bus.hit2       = w_hit[1];
  assign io_bus.score2     = w_score[1];
  assign io_bus.state2_dbg = w_state[1];

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: per-cycle vector table for bullet 1, then hand-written
// sequences for score saturation, cooldown, simultaneous hits and reset mid-flight.
module tb_bullet_controller;

  logic Clk = 1'b0;
  logic Reset;

  bullet_controller_if bus ();

  bullet_controller u_dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .io_bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       tick;
    logic       f1;
    logic [1:0] d1;
    logic [9:0] b1x, b1y, b2x, b2y;
    logic       chk;
    logic       on1;
    logic [9:0] x1, y1;
    logic       h1;
    logic [3:0] s1;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  seg_d1;
  logic [9:0]  seg_b1x, seg_b1y, seg_b2x, seg_b2y;
  logic [25:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic set_seg(input logic [1:0] d1, input logic [9:0] b1x, b1y, b2x, b2y);
    seg_d1 = d1; seg_b1x = b1x; seg_b1y = b1y; seg_b2x = b2x; seg_b2y = b2y;
  endtask

  task automatic add_v(input logic rst, tick, f1, chk, on1,
                       input logic [9:0] x1, y1, input logic h1, input logic [3:0] s1);
    vec_t v;
    v.rst = rst; v.tick = tick; v.f1 = f1; v.d1 = seg_d1;
    v.b1x = seg_b1x; v.b1y = seg_b1y; v.b2x = seg_b2x; v.b2y = seg_b2y;
    v.chk = chk; v.on1 = on1; v.x1 = x1; v.y1 = y1; v.h1 = h1; v.s1 = s1;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic tick, f1, f2);
    bus.frame_tick = tick;
    bus.fire1      = f1;
    bus.fire2      = f2;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
  endtask

  task automatic set_balls(input logic [9:0] b1x, b1y, b2x, b2y, input logic [1:0] d1, d2);
    bus.BallX = b1x; bus.BallY = b1y; bus.Ball2X = b2x; bus.Ball2Y = b2y;
    bus.dir1 = d1; bus.dir2 = d2;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [3:0] exp_score;
  logic       bad;

  initial begin
    Reset = 1'b1;
    bus.frame_tick = 1'b0; bus.fire1 = 1'b0; bus.fire2 = 1'b0;
    set_balls(10'd0, 10'd0, 10'd0, 10'd0, 2'd0, 2'd0);

    // Fire held through reset; release, then a fresh press launches.
    set_seg(2'd1, 10'd50, 10'd60, 10'd300, 10'd300);
    add_v(1, 0, 1, 1, 0,   0,   0, 0, 0);
    add_v(1, 0, 1, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 1,  50,  60, 0, 0);
    add_v(0, 0, 1, 1, 1,  50,  60, 0, 0);
    add_v(0, 1, 1, 1, 1,  54,  60, 0, 0);
    // Right-edge expiry from X=620 (reset lands mid-flight).
    set_seg(2'd1, 10'd620, 10'd100, 10'd100, 10'd400);
    add_v(1, 0, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 1, 620, 100, 0, 0);
    add_v(0, 1, 1, 1, 1, 624, 100, 0, 0);
    add_v(0, 1, 1, 1, 1, 628, 100, 0, 0);
    add_v(0, 1, 1, 1, 1, 632, 100, 0, 0);
    add_v(0, 1, 1, 1, 1, 636, 100, 0, 0);
    add_v(0, 1, 1, 1, 0, 636, 100, 0, 0);
    add_v(0, 0, 0, 1, 0, 636, 100, 0, 0);
    // Left-edge expiry from X=10.
    set_seg(2'd3, 10'd10, 10'd100, 10'd300, 10'd300);
    add_v(1, 0, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 1,  10, 100, 0, 0);
    add_v(0, 1, 1, 1, 1,   6, 100, 0, 0);
    add_v(0, 1, 1, 1, 1,   2, 100, 0, 0);
    add_v(0, 1, 1, 1, 0,   2, 100, 0, 0);
    add_v(0, 1, 0, 1, 0,   2, 100, 0, 0);
    // Hit at |dx|=8; hit beats the move on the same tick.
    set_seg(2'd1, 10'd100, 10'd200, 10'd120, 10'd200);
    add_v(1, 0, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 0, 1, 0,   0,   0, 0, 0);
    add_v(0, 1, 1, 1, 1, 100, 200, 0, 0);
    add_v(0, 1, 1, 1, 1, 104, 200, 0, 0);
    add_v(0, 1, 1, 1, 1, 108, 200, 0, 0);
    add_v(0, 1, 1, 1, 1, 112, 200, 0, 0);
    add_v(0, 1, 1, 1, 0, 112, 200, 1, 1);
    add_v(0, 0, 1, 1, 0, 112, 200, 0, 1);
    add_v(0, 0, 0, 1, 0, 112, 200, 0, 1);

    foreach (vecs[i]) begin
      Reset = vecs[i].rst;
      bus.fire2 = 1'b0;
      set_balls(vecs[i].b1x, vecs[i].b1y, vecs[i].b2x, vecs[i].b2y, vecs[i].d1, 2'd0);
      cyc(vecs[i].tick, vecs[i].f1, 1'b0);
      if (vecs[i].chk) begin
        exp_q.push_back({vecs[i].on1, vecs[i].x1, vecs[i].y1, vecs[i].h1, vecs[i].s1});
        check($sformatf("vec%0d on/x/y/hit/score", i),
              {38'd0, bus.bullet_on, bus.BulletX, bus.BulletY, bus.hit1, bus.score1},
              {38'd0, exp_q.pop_front()});
      end
    end

    // Spawn-on-opponent hits, 16 in a row: score saturates at 15.
    set_balls(10'd200, 10'd200, 10'd200, 10'd200, 2'd0, 2'd0);
    do_reset();
    exp_score = 4'd0;
    for (int r = 0; r < 16; r++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      if (exp_score != 4'hF) exp_score = exp_score + 4'd1;
      check($sformatf("spawn_hit%0d hit/on/score", r),
            {58'd0, bus.hit1, bus.bullet_on, bus.score1}, {58'd0, 1'b1, 1'b0, exp_score});
      cyc(1'b0, 1'b0, 1'b0);
      if (r < 15) begin
        for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, 1'b0);
      end
    end
    check("hit_single_cycle", {63'd0, bus.hit1}, 64'd0);

    // Presses during cooldown are ignored; the 30th tick returns to IDLE.
    bad = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      cyc(1'b1, k[0], 1'b0);
      if (bus.bullet_on) bad = 1'b1;
    end
    check("cool_press_ignored", {63'd0, bad}, 64'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("cool_state_tick29", {62'd0, bus.state1_dbg}, 64'd3);
    cyc(1'b1, 1'b1, 1'b0);
    check("cool_end_tick30 state/on", {61'd0, bus.state1_dbg, bus.bullet_on}, 64'd0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("refire on/x/y", {43'd0, bus.bullet_on, bus.BulletX, bus.BulletY},
          {43'd0, 1'b1, 10'd200, 10'd200});

    // Face-to-face shots: both hit in the same cycle.
    set_balls(10'd100, 10'd200, 10'd116, 10'd200, 2'd1, 2'd3);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("dual_launch pos", {24'd0, bus.BulletX, bus.BulletY, bus.Bullet2X, bus.Bullet2Y},
          {24'd0, 10'd100, 10'd200, 10'd116, 10'd200});
    check("dual_launch on", {62'd0, bus.bullet_on, bus.bullet2_on}, 64'd3);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    check("dual_pre_hit x", {44'd0, bus.BulletX, bus.Bullet2X, bus.hit1, bus.hit2},
          {44'd0, 10'd108, 10'd108, 2'b00});
    cyc(1'b0, 1'b1, 1'b1);
    check("dual_hit hit/on/scores", {52'd0, bus.hit1, bus.hit2, bus.bullet_on, bus.bullet2_on,
          bus.score1, bus.score2}, {52'd0, 4'b1100, 4'd1, 4'd1});
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("dual_relaunch on/scores", {54'd0, bus.bullet_on, bus.bullet2_on, bus.score1, bus.score2},
          {54'd0, 2'b11, 4'd1, 4'd1});

    // Reset while both bullets are in flight.
    Reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);
    Reset = 1'b0;
    check("reset_midfly pos", {24'd0, bus.BulletX, bus.BulletY, bus.Bullet2X, bus.Bullet2Y}, 64'd0);
    check("reset_midfly flags", {48'd0, bus.bullet_on, bus.bullet2_on, bus.hit1, bus.hit2,
          bus.score1, bus.score2, bus.state1_dbg, bus.state2_dbg}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bullet_controller.md
Name: bullet_controller

Overview:
- Sequences the two player bullets for the two-player arena: firing, per-frame flight, screen-edge expiry, hit detection against the opposing ball, cooldown and score keeping.
- Drives bullet position/enable into the color mapper; consumes ball positions from the ball motion blocks and fire/direction inputs from the keyboard decode.
- Two identical per-bullet FSMs share one frame tick; each targets only the opposing player.

Parameters:
- X_MAX, 639, largest legal bullet X coordinate.
- Y_MAX, 479, largest legal bullet Y coordinate.
- SPEED, 4, pixels moved per frame tick.
- HIT_DIST, 8, hit when both |dx| and |dy| <= HIT_DIST (ball half-size 4 + bullet radius 4).
- COOLDOWN, 30, frames a player must wait after a bullet ends before it can fire again.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame, synchronous to Clk.
- fire1, fire2  in  1 each  level fire request, player 1 and player 2 (keyboard).
- dir1, dir2  in  2 each  facing direction: 0 up, 1 right, 2 down, 3 left.
- BallX, BallY, Ball2X, Ball2Y  in  10 each  ball centres of player 1 and player 2.
- BulletX, BulletY, Bullet2X, Bullet2Y  out  10 each  bullet centres, registered.
- bullet_on, bullet2_on  out  1 each  bullet visible, registered.
- hit1, hit2  out  1 each  one-Clk pulse: bullet 1 hit ball 2, bullet 2 hit ball 1.
- score1, score2  out  4 each  hit counts, saturating at 15.

Behaviour:
- Reset (sync, any state):
  - Both FSMs go to IDLE.
  - Positions 0, bullet_on/bullet2_on 0, hit pulses 0, scores 0, cooldown counters 0.
  - fire_prev registers are set to 1, so a fire held through reset must be released before it can launch.
- Per-bullet FSM states: IDLE, FLY, HIT, COOL. The description below is for bullet 1; bullet 2 is a mirror with player indices swapped.
- Edge detection: fire_prev is updated only on frame_tick. A launch request is fire1=1 AND fire_prev=0 at a frame_tick.
- IDLE: on a launch request at cycle T:
  - latch Bullet := (BallX, BallY) and latch dir1.
  - state FLY and bullet_on=1 from T+1.
  - Requests while not IDLE are ignored and are not queued.
- FLY, evaluated every Clk, with hit taking priority over movement:
  - Hit: |BulletX-BallX2| <= HIT_DIST and |BulletY-Ball2Y| <= HIT_DIST, using 11-bit unsigned absolute difference. On hit, go to HIT next cycle.
  - Otherwise, on frame_tick, step SPEED in the latched direction.
  - Up/left: if coordinate < SPEED, the bullet expires; else coordinate -= SPEED.
  - Down/right: if coordinate + SPEED > Y_MAX/X_MAX, the bullet expires; else coordinate += SPEED. Compute the sum at 11 bits so there is no wrap.
  - Expire: go to COOL next cycle with bullet_on=0, and load the cooldown counter with COOLDOWN.
  - The bullet never occupies a coordinate outside 0..MAX.
- HIT (exactly 1 cycle):
  - hit1=1 and bullet_on=0.
  - score1 := min(score1+1, 15).
  - Load the cooldown counter with COOLDOWN, then go to COOL.
- COOL: decrement the counter on each frame_tick. On the frame_tick where the counter equals 1, go to IDLE.
  - fire_prev still tracks fire during COOL, so holding fire through cooldown does not auto-fire on return to IDLE.
- Latency:
  - Launch to visible: 1 Clk after frame_tick.
  - Hit detect to hit pulse: 1 Clk.
  - Bullet end to re-fire: COOLDOWN frame ticks plus the next frame tick carrying a fresh press.
- Spawn on opponent (balls overlapping): the hit fires on the first FLY cycle, which is legal.
- The two FSMs are fully independent:
  - Simultaneous hits pulse both hit1 and hit2 in the same cycle and update both scores.
  - Simultaneous launches are both accepted.
- Outputs hold their last values while in COOL/IDLE. Consumers must qualify the outputs with bullet_on.
- frame_tick asserted on consecutive cycles is treated as separate frames (no filtering).

Test Plan:
- Reset release with fire1=1 held, then 3 frame_ticks -> bullet_on stays 0. Release fire1, press again at tick 5 -> bullet_on=1, BulletX/Y = BallX/BallY one Clk later.
- Fire1 with dir1=1, BallX=620, BallY=100, Ball2 far -> X steps 624, 628, 632, 636. On the next tick (636+4>639) bullet_on drops and no hit1 pulse occurs.
- Fire1 with dir1=3 from X=10 -> X steps 6, 2. On the next tick it expires; bullet X never wraps above 639.
- Ball at (100,200) firing right, Ball2 at (120,200) -> hit1 pulses once at X=112 (|dx|=8), score1 goes 0->1, bullet_on=0 the same cycle as the pulse.
- score1=15, another hit -> hit1 pulses and score1 stays 15. Fire pressed during cooldown (COOLDOWN=30) is ignored. A fresh press on a frame tick after 30 ticks launches.
- Both players fire at each other on the same tick from (100,200)/(116,200) -> hit1 and hit2 pulse in the same cycle and both scores increment. Reset asserted mid-FLY -> next cycle all outputs are at their reset values.
